// File: rtl/conway_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conway_sequencer
// Purpose  : Loads a Game of Life board pattern serially, commits it to the
//            cell array, then advances generations on demand or free-running.
// Revision : 1.0 - initial release
// ============================================================================
module conway_sequencer #(
    parameter int N_ROWS   = 8,
    parameter int N_COLS   = 8,
    parameter int TICK_DIV = 1000000,
    parameter int GEN_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_start,
    input  logic                       load_valid,
    input  logic                       load_bit,
    output logic                       load_ready,
    input  logic                       run,
    input  logic                       pause,
    input  logic                       step,
    input  logic                       board_changed,
    output logic [N_ROWS*N_COLS-1:0]   init_pattern,
    output logic                       grid_rst,
    output logic                       grid_ena,
    output logic [GEN_W-1:0]           generation,
    output logic                       running,
    output logic                       stable
);

    localparam int c_n      = N_ROWS * N_COLS;
    localparam int c_cnt_w  = (c_n > 1) ? $clog2(c_n) : 1;
    localparam int c_tick_w = $clog2(TICK_DIV);

    localparam logic [c_cnt_w-1:0]  c_last_bit  = c_cnt_w'(c_n - 1);
    localparam logic [c_tick_w-1:0] c_last_tick = c_tick_w'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_COMMIT = 3'd2,
        S_PAUSED = 3'd3,
        S_RUN    = 3'd4,
        S_STABLE = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_n-1:0]      r_pattern;
    logic [c_n-1:0]      w_pattern_nxt;
    logic [c_cnt_w-1:0]  r_bit_cnt;
    logic [c_cnt_w-1:0]  w_bit_cnt_nxt;
    logic [c_tick_w-1:0] r_tick;
    logic [c_tick_w-1:0] w_tick_nxt;
    logic [GEN_W-1:0]    r_generation;
    logic [GEN_W-1:0]    w_gen_nxt;
    logic [GEN_W-1:0]    w_gen_inc;
    logic                w_ena_nxt;
    logic                w_grst_nxt;
    logic                r_grid_ena;
    logic                r_grid_rst;
    logic                r_load_ready;
    logic                r_running;
    logic                r_stable;

    // Saturating increment; the grid still advances once the count pins.
    assign w_gen_inc = (r_generation == {GEN_W{1'b1}}) ? r_generation
                                                       : r_generation + 1'b1;

    always_comb begin
        w_state_nxt   = r_state;
        w_pattern_nxt = r_pattern;
        w_bit_cnt_nxt = r_bit_cnt;
        w_tick_nxt    = r_tick;
        w_gen_nxt     = r_generation;
        w_ena_nxt     = 1'b0;
        w_grst_nxt    = 1'b0;

        if (load_start && (r_state != S_COMMIT)) begin
            w_state_nxt   = S_LOAD;
            w_bit_cnt_nxt = '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (load_valid) begin
                        w_pattern_nxt[r_bit_cnt] = load_bit;
                        if (r_bit_cnt == c_last_bit) begin
                            w_state_nxt   = S_COMMIT;
                            w_grst_nxt    = 1'b1;
                            w_bit_cnt_nxt = '0;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    w_gen_nxt   = '0;
                    w_state_nxt = S_PAUSED;
                end
                S_PAUSED: begin
                    if (pause) begin
                        w_state_nxt = S_PAUSED;
                    end else if (run) begin
                        w_state_nxt = S_RUN;
                        w_tick_nxt  = '0;
                    end else if (step) begin
                        if (board_changed) begin
                            w_ena_nxt = 1'b1;
                            w_gen_nxt = w_gen_inc;
                        end else begin
                            w_state_nxt = S_STABLE;
                        end
                    end
                end
                S_RUN: begin
                    // pause outranks the terminal count, so no pulse escapes
                    if (pause) begin
                        w_state_nxt = S_PAUSED;
                        w_tick_nxt  = '0;
                    end else if (r_tick == c_last_tick) begin
                        w_tick_nxt = '0;
                        if (board_changed) begin
                            w_ena_nxt = 1'b1;
                            w_gen_nxt = w_gen_inc;
                        end else begin
                            w_state_nxt = S_STABLE;
                        end
                    end else begin
                        w_tick_nxt = r_tick + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (pause) begin
                        w_state_nxt = S_PAUSED;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pattern    <= '0;
            r_bit_cnt    <= '0;
            r_tick       <= '0;
            r_generation <= '0;
            r_grid_ena   <= 1'b0;
            r_grid_rst   <= 1'b0;
            r_load_ready <= 1'b0;
            r_running    <= 1'b0;
            r_stable     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pattern    <= w_pattern_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_tick       <= w_tick_nxt;
            r_generation <= w_gen_nxt;
            r_grid_ena   <= w_ena_nxt;
            r_grid_rst   <= w_grst_nxt;
            r_load_ready <= (w_state_nxt == S_LOAD);
            r_running    <= (w_state_nxt == S_RUN);
            r_stable     <= (w_state_nxt == S_STABLE);
        end
    end

    assign init_pattern = r_pattern;
    assign grid_rst     = r_grid_rst;
    assign grid_ena     = r_grid_ena;
    assign generation   = r_generation;
    assign load_ready   = r_load_ready;
    assign running      = r_running;
    assign stable       = r_stable;

endmodule
`default_nettype wire

// File: doc/conway_sequencer.md
# conway_sequencer

Generation sequencer for the Game of Life cell array. It serially loads an initial board pattern and commits it to the array, then advances generations on demand (single-step) or free-running at a fixed cycle period. Advancement stops automatically when the board reaches a still life. It sits between the user/host control inputs and the grid, driving the grid's shared enable and reset.

## Interface
- N_ROWS, 8, board rows
- N_COLS, 8, board columns; N = N_ROWS*N_COLS cells
- TICK_DIV, 1000000, clock cycles per generation in RUN (>= 2)
- GEN_W, 16, generation counter width

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load_start  in  1  pulse: begin (or restart) pattern load
- load_valid  in  1  load_bit valid this cycle
- load_bit  in  1  pattern bit, cell 0 first, cell N-1 last
- load_ready  out  1  high while in LOAD
- run  in  1  pulse: enter free-running mode
- pause  in  1  pulse: leave free-running mode
- step  in  1  pulse: advance exactly one generation
- board_changed  in  1  from grid, combinational: some cell's next state differs from its current state
- init_pattern  out  N  pattern register, drives cell initial-state inputs
- grid_rst  out  1  one-cycle pulse that loads init_pattern into the cells
- grid_ena  out  1  one-cycle pulse that advances every cell one generation
- generation  out  GEN_W  generations advanced since last commit, saturating
- running  out  1  high in RUN
- stable  out  1  high in STABLE

## Operation
- States: IDLE, LOAD, COMMIT, PAUSED, RUN, STABLE.
- Reset: state IDLE. init_pattern, generation, bit counter, and tick counter are 0. All 1-bit outputs are 0.
- Command priority when several pulses coincide: load_start > pause > run > step.
- load_start is accepted in every state except COMMIT. It moves to LOAD and clears the bit counter. init_pattern is kept until overwritten.
- IDLE: only load_start has effect.
- LOAD: load_ready=1. Each cycle with load_valid=1 writes load_bit into init_pattern[bit counter] and increments the counter. The cycle that accepts bit N-1 moves to COMMIT.
- COMMIT: lasts one cycle. grid_rst=1 and generation<=0, then go to PAUSED.
- PAUSED:
  - run → RUN with tick counter 0.
  - step: sample board_changed. If it is 1, pulse grid_ena in the next cycle, increment generation, and stay PAUSED. If it is 0, go to STABLE with no pulse.
- RUN: the tick counter counts 0..TICK_DIV-1 and wraps.
  - In the cycle where the counter is TICK_DIV-1, sample board_changed. If it is 1, pulse grid_ena next cycle and increment generation. If it is 0, go to STABLE with no pulse.
  - pause → PAUSED and clear the tick counter. If pause coincides with the terminal count, pause wins and no pulse is issued.
  - step is ignored in RUN.
- STABLE: stable=1. run and step are ignored. pause → PAUSED (stable drops). load_start → LOAD.
- generation saturates at 2^GEN_W-1. grid_ena still pulses after saturation.
- grid_ena and grid_rst are never high in the same cycle. grid_ena is never high outside the cycle after a qualifying step or terminal count.

## Timing
- All outputs are registered.
- load_bit sampled in cycle t appears in init_pattern at t+1.
- The last bit accepted in cycle t gives grid_rst=1 in cycle t+1 and PAUSED from cycle t+2.
- step sampled in cycle t gives grid_ena=1 in cycle t+1. generation updates at the same edge, so it is visible in cycle t+1.
- run sampled in cycle t: running=1 from t+1. The first grid_ena occurs in cycle t+TICK_DIV+1, then one pulse every TICK_DIV cycles.
- Stability detection: stable=1 in the cycle after the sampling cycle.
- rst overrides everything on the next edge, mid-load or mid-run. A pending grid_ena is cancelled.

## Test plan
All scenarios use N_ROWS=N_COLS=4, TICK_DIV=4, GEN_W=4.
- Reset → all outputs 0. Then load_start plus 16 valid bits of 0xA5C3 (cell 0 first) → init_pattern=0xA5C3, exactly one grid_rst pulse, generation=0, state PAUSED.
- Load with load_valid gaps (valid every other cycle), plus a second load_start after 7 bits → counter restarts. The final init_pattern reflects only the 16 bits after the restart.
- PAUSED, board_changed=1, three step pulses 2 cycles apart → exactly 3 grid_ena pulses, each 1 cycle after its step; generation=3.
- run with board_changed=1 → grid_ena pulses at t+5, t+9, t+13. pause coinciding with the 4th terminal count → no 4th pulse, running=0.
- RUN with board_changed dropping to 0 before a terminal count → no pulse, stable=1 next cycle. Later step and run have no effect; load_start → LOAD.
- 20 steps from generation=0 → generation holds at 15 while grid_ena keeps pulsing. rst mid-RUN one cycle before a pulse → no pulse, all outputs 0.
